// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage.
//   RESET_PC_DEFAULT : first fetch address after reset
//   INSTR_NOP        : all-zero word used as a bubble in Decode
//   hold_state_e     : state of the Decode-side instruction hold buffer
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  typedef enum logic {
    HbEmpty,
    HbHeld
  } hold_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// Holds the Decode instruction word across a Decode stall. While Decode
// stalls the SRAM keeps returning data for the (held) fetch address, which
// is the *next* instruction, so the word in Decode must be captured on the
// first stalled edge and replayed until the stall ends.
//   clk, rst  : clock, synchronous active-high reset (to empty)
//   stall     : Decode stall
//   flush     : Decode flush; empties the buffer, wins over stall
//   live_word : word currently presented to Decode when not holding
//   held      : buffer holds a captured word
//   held_word : captured word
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] live_word,
  output logic        held,
  output logic [31:0] held_word
);

  hold_state_e state_q, state_d;
  logic [31:0] word_q;
  logic        capture;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      HbEmpty: begin
        if (stall && !flush) begin
          state_d = HbHeld;
          capture = 1'b1;
        end
      end
      HbHeld: begin
        if (!stall || flush) begin
          state_d = HbEmpty;
        end
      end
      default: state_d = HbEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HbEmpty;
      word_q  <= INSTR_NOP;
    end else begin
      state_q <= state_d;
      if (capture) begin
        word_q <= live_word;
      end
    end
  end

  assign held      = (state_q == HbHeld);
  assign held_word = word_q;

endmodule

// File: rtl/flopenrc.sv
// Generic flop with enable and synchronous clear.
// Priority: rst > clr > en.
//   clk, rst : clock, synchronous active-high reset (loads RESET_VAL)
//   en       : load d when high
//   clr      : load zero when high
//   d, q     : data in / out
module flopenrc #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS-style instruction fetch stage with IF/ID pipeline register.
// Optional misaligned-fetch detection when FETCH_ADEL_CHECK_EN is defined;
// otherwise adelD is tied low and no alignment logic exists.
//   clk, rst                : clock, synchronous active-high reset
//   stallF, stallD, flushD  : hazard controls for PC and IF/ID
//   branch_takenD/targetD   : taken branch redirect
//   jumpD/jump_targetD      : J/JAL redirect
//   jrD/jr_targetD          : JR/JALR redirect (highest priority)
//   inst_sram_*             : instruction SRAM port, data one cycle after addr
//   pcF                     : fetch PC
//   pcD, pcplus4D, instrD   : IF/ID contents presented to Decode
//   adelD                   : misaligned-fetch flag for the Decode instruction
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        branch_takenD,
  input  logic [31:0] branch_targetD,
  input  logic        jumpD,
  input  logic [31:0] jump_targetD,
  input  logic        jrD,
  input  logic [31:0] jr_targetD,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic [31:0] instrD,
  output logic        adelD
);

  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        id_en;
  logic        id_clr;
  logic        valid_d;
  logic [31:0] live_word;
  logic        held;
  logic [31:0] held_word;
  logic [31:0] instr_sel;

  assign pc_plus4 = pcF + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    if (jrD) begin
      pc_next = jr_targetD;
    end else if (jumpD) begin
      pc_next = jump_targetD;
    end else if (branch_takenD) begin
      pc_next = branch_targetD;
    end
  end

  // A redirect presented while stallF is high is dropped; the hazard unit
  // keeps it asserted until the stall clears.
  flopenrc #(
    .WIDTH    (32),
    .RESET_VAL(RESET_PC)
  ) u_pc (
    .clk(clk),
    .rst(rst),
    .en (!stallF),
    .clr(1'b0),
    .d  (pc_next),
    .q  (pcF)
  );

  // Fetch stalled but Decode moving: the SRAM will return the same word
  // again, so Decode gets a bubble instead of a duplicate.
  assign id_en  = !stallD;
  assign id_clr = flushD || (stallF && !stallD);

  flopenrc #(.WIDTH(32)) u_pc_d (
    .clk(clk),
    .rst(rst),
    .en (id_en),
    .clr(id_clr),
    .d  (pcF),
    .q  (pcD)
  );

  flopenrc #(.WIDTH(32)) u_pcplus4_d (
    .clk(clk),
    .rst(rst),
    .en (id_en),
    .clr(id_clr),
    .d  (pc_plus4),
    .q  (pcplus4D)
  );

  // Marks the Decode slot as holding a real fetched instruction.
  flopenrc #(.WIDTH(1)) u_valid_d (
    .clk(clk),
    .rst(rst),
    .en (id_en),
    .clr(id_clr),
    .d  (1'b1),
    .q  (valid_d)
  );

  assign live_word = valid_d ? inst_sram_rdata : INSTR_NOP;

  fetch_hold_buf u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .stall    (stallD),
    .flush    (flushD),
    .live_word(live_word),
    .held     (held),
    .held_word(held_word)
  );

  assign instr_sel = held ? held_word : live_word;

`ifdef FETCH_ADEL_CHECK_EN
  logic adel_q;

  flopenrc #(.WIDTH(1)) u_adel_d (
    .clk(clk),
    .rst(rst),
    .en (id_en),
    .clr(id_clr),
    .d  (|pcF[1:0]),
    .q  (adel_q)
  );

  assign adelD  = adel_q;
  assign instrD = adel_q ? INSTR_NOP : instr_sel;
`else
  assign adelD  = 1'b0;
  assign instrD = instr_sel;
`endif

  assign inst_sram_en   = !rst;
  assign inst_sram_addr = pcF;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-cycle-latency SRAM model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, flushD;
  logic        branch_takenD, jumpD, jrD;
  logic [31:0] branch_targetD, jump_targetD, jr_targetD;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic [31:0] pcF, pcD, pcplus4D, instrD;
  logic        adelD;
  logic        force_dead;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stallF         (stallF),
    .stallD         (stallD),
    .flushD         (flushD),
    .branch_takenD  (branch_takenD),
    .branch_targetD (branch_targetD),
    .jumpD          (jumpD),
    .jump_targetD   (jump_targetD),
    .jrD            (jrD),
    .jr_targetD     (jr_targetD),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .pcF            (pcF),
    .pcD            (pcD),
    .pcplus4D       (pcplus4D),
    .instrD         (instrD),
    .adelD          (adelD)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return ~a;
  endfunction

  always @(posedge clk) begin
    inst_sram_rdata <= force_dead ? 32'hDEAD_BEEF : mem(inst_sram_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stallF = 0; stallD = 0; flushD = 0;
    branch_takenD = 0; jumpD = 0; jrD = 0;
  endtask

  initial begin
    rst = 1'b1; force_dead = 1'b0;
    branch_targetD = '0; jump_targetD = '0; jr_targetD = '0;
    idle();
    step(); step();
    check("rst_pcF", pcF, 32'hBFC0_0000);
    check("rst_pcD", pcD, 32'h0);
    check("rst_pcplus4D", pcplus4D, 32'h0);
    check("rst_instrD", instrD, 32'h0);
    check("rst_adelD", {31'b0, adelD}, 32'h0);
    check("rst_en", {31'b0, inst_sram_en}, 32'h0);

    // Reset release, one-cycle latency
    rst = 1'b0;
    #1 check("en_after_rst", {31'b0, inst_sram_en}, 32'h1);
    step();
    check("c1_pcF", pcF, 32'hBFC0_0004);
    check("c1_pcD", pcD, 32'hBFC0_0000);
    check("c1_pcplus4D", pcplus4D, 32'hBFC0_0004);
    check("c1_instrD", instrD, 32'h2402_0005);
    step();
    check("c2_pcF", pcF, 32'hBFC0_0008);
    check("c2_instrD", instrD, ~32'hBFC0_0004);
    check("c2_addr", inst_sram_addr, 32'hBFC0_0008);

    // Jump: delay slot still reaches Decode
    jumpD = 1; jump_targetD = 32'hBFC0_0100;
    step();
    idle();
    check("jmp_pcF", pcF, 32'hBFC0_0100);
    check("jmp_slot_pcD", pcD, 32'hBFC0_0008);
    check("jmp_slot_instrD", instrD, ~32'hBFC0_0008);
    step();
    check("jmp_tgt_pcD", pcD, 32'hBFC0_0100);
    check("jmp_tgt_instrD", instrD, ~32'hBFC0_0100);

    // Full stall with changing SRAM data
    stallF = 1; stallD = 1; force_dead = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instrD", instrD, ~32'hBFC0_0100);
      check("stall_pcF", pcF, 32'hBFC0_0104);
      check("stall_pcD", pcD, 32'hBFC0_0100);
    end
    idle(); force_dead = 0;
    step();
    check("unstall_pcD", pcD, 32'hBFC0_0104);
    check("unstall_instrD", instrD, ~32'hBFC0_0104);
    check("unstall_pcF", pcF, 32'hBFC0_0108);

    // Fetch-only stall inserts a bubble
    stallF = 1;
    step();
    idle();
    check("bubble_instrD", instrD, 32'h0);
    check("bubble_pcF", pcF, 32'hBFC0_0108);
    step();
    check("post_bubble_pcD", pcD, 32'hBFC0_0108);
    check("post_bubble_instrD", instrD, ~32'hBFC0_0108);

    // Hold, then flush together with stall empties the buffer
    stallF = 1; stallD = 1;
    step();
    check("hold2_instrD", instrD, ~32'hBFC0_0108);
    flushD = 1;
    step();
    check("flush_instrD", instrD, 32'h0);
    check("flush_pcD", pcD, 32'h0);
    check("flush_pcplus4D", pcplus4D, 32'h0);
    check("flush_pcF", pcF, 32'hBFC0_010C);
    idle();
    step();
    check("postflush_pcD", pcD, 32'hBFC0_010C);
    check("postflush_instrD", instrD, ~32'hBFC0_010C);

    // Redirect priority
    jrD = 1; jr_targetD = 32'hBFC0_0200;
    branch_takenD = 1; branch_targetD = 32'hBFC0_0300;
    step();
    check("jr_over_br", pcF, 32'hBFC0_0200);
    jrD = 0; jumpD = 1; jump_targetD = 32'hBFC0_0400;
    step();
    check("j_over_br", pcF, 32'hBFC0_0400);
    jumpD = 0;
    step();
    check("br_only", pcF, 32'hBFC0_0300);
    idle();

    // Redirect during fetch stall is dropped
    stallF = 1; jrD = 1; jr_targetD = 32'hBFC0_0500;
    step();
    check("stalled_redirect", pcF, 32'hBFC0_0300);
    idle();

    // PC wraps to zero
    jrD = 1; jr_targetD = 32'hFFFF_FFFC;
    step();
    idle();
    check("wrap_pre", pcF, 32'hFFFF_FFFC);
    step();
    check("wrap_pcF", pcF, 32'h0);
    check("wrap_pcD", pcD, 32'hFFFF_FFFC);
    check("wrap_pcplus4D", pcplus4D, 32'h0);

    // Misaligned fetch
    jrD = 1; jr_targetD = 32'hBFC0_0102;
    step();
    idle();
    check("mis_pcF", pcF, 32'hBFC0_0102);
    step();
    check("mis_pcD", pcD, 32'hBFC0_0102);
`ifdef FETCH_ADEL_CHECK_EN
    check("mis_adelD", {31'b0, adelD}, 32'h1);
    check("mis_instrD", instrD, 32'h0);
`else
    check("mis_adelD", {31'b0, adelD}, 32'h0);
    check("mis_instrD", instrD, ~32'hBFC0_0102);
`endif
    step();
    check("mis_next_pcD", pcD, 32'hBFC0_0106);

    // Reset pulse during a held stall
    stallF = 1; stallD = 1;
    step();
    check("prerst_hold", instrD, ~32'hBFC0_0106);
    rst = 1;
    step();
    check("rst_mid_pcF", pcF, 32'hBFC0_0000);
    check("rst_mid_instrD", instrD, 32'h0);
    check("rst_mid_pcD", pcD, 32'h0);
    check("rst_mid_en", {31'b0, inst_sram_en}, 32'h0);
    rst = 0; idle();
    step();
    check("rst2_pcD", pcD, 32'hBFC0_0000);
    check("rst2_instrD", instrD, 32'h2402_0005);
    check("rst2_pcF", pcF, 32'hBFC0_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 stallF  input  1  holds pcF.
REQ-005 stallD  input  1  holds the IF/ID contents (pcD, pcplus4D, instrD).
REQ-006 flushD  input  1  replaces the IF/ID contents with a bubble on the next edge.
REQ-007 branch_takenD  input  1  taken conditional branch in Decode.
REQ-008 branch_targetD  input  32  branch target address.
REQ-009 jumpD  input  1  J/JAL in Decode.
REQ-010 jump_targetD  input  32  J/JAL target address.
REQ-011 jrD  input  1  JR/JALR in Decode.
REQ-012 jr_targetD  input  32  register target address.
REQ-013 inst_sram_en  output  1  instruction SRAM read enable.
REQ-014 inst_sram_addr  output  32  instruction SRAM read address; equals pcF.
REQ-015 inst_sram_rdata  input  32  SRAM read data, valid exactly one cycle after the address.
REQ-016 pcF  output  32  current fetch PC.
REQ-017 pcD  output  32  PC of the instruction in Decode.
REQ-018 pcplus4D  output  32  pcD+4.
REQ-019 instrD  output  32  instruction word presented to the main decoder.
REQ-020 adelD  output  1  misaligned-fetch flag for the instruction in Decode.

Function
REQ-021 pc_next SHALL be selected by priority: jrD -> jr_targetD, then jumpD -> jump_targetD, then branch_takenD -> branch_targetD, else pcF+4 (modulo 2^32, wraps at 0xFFFF_FFFC to 0).
REQ-022 pcF SHALL load pc_next on every edge with stallF=0 and SHALL hold while stallF=1; a redirect asserted while stallF=1 is dropped, and the hazard unit re-presents it.
REQ-023 Delay-slot semantics SHALL be preserved: the instruction at branch PC+4 is always fetched and passed to Decode, never flushed by this block.
REQ-024 inst_sram_en SHALL be 1 whenever rst=0.
REQ-025 The IF/ID register SHALL update with priority flush > stall > load: on flushD, pcD=0, pcplus4D=0, instrD=0 (NOP); on stallD, all hold; otherwise pcD<=pcF and pcplus4D<=pcF+4.
REQ-026 If stallF=1 and stallD=0 with no flush, IF/ID SHALL load a bubble (instrD=0).
REQ-027 A hold buffer (state EMPTY/HELD) SHALL capture inst_sram_rdata on the first stallD cycle (EMPTY->HELD) and drive instrD from the buffer while HELD; it returns to EMPTY on the first edge with stallD=0, or on flushD.
REQ-028 In EMPTY, instrD SHALL equal inst_sram_rdata, or 0 when the D slot holds a bubble; in HELD it SHALL equal the captured word, independent of SRAM data.
REQ-029 With no stalls, the latency from pcF=X to instrD=mem[X] and pcD=X SHALL be one cycle.

Reset
REQ-030 While rst=1: pcF=RESET_PC, pcD=0, pcplus4D=0, instrD=0, adelD=0, hold buffer EMPTY, inst_sram_en=0.
REQ-031 A reset asserted mid-stall SHALL discard HELD contents; the first fetch after reset is RESET_PC.

Configuration
REQ-032 Macro FETCH_ADEL_CHECK_EN defined: adelD SHALL be registered as (pcF[1:0]!=0) alongside pcD, and instrD SHALL be forced to 0 when adelD=1.
REQ-033 Macro FETCH_ADEL_CHECK_EN undefined: adelD SHALL be tied to 0 and no alignment logic SHALL be built.

Structure
REQ-034 The shared defines package SHALL hold RESET_PC_DEFAULT (32'hBFC0_0000) and INSTR_NOP (32'h0000_0000).
REQ-035 The hold buffer SHALL be a sub-module named fetch_hold_buf; the PC and IF/ID registers SHALL use the existing enable/clear flop primitives.

Verification
REQ-036 Reset release with no stalls, mem[0xBFC00000]=0x24020005 -> cycle 1: pcF=0xBFC00004, pcD=0xBFC00000, instrD=0x24020005.
REQ-037 jumpD=1, jump_targetD=0xBFC00100 at pcF=0xBFC00008 -> delay slot 0xBFC00008 reaches Decode; next pcF=0xBFC00100.
REQ-038 stallF=stallD=1 for 3 cycles while SRAM data changes to 0xDEADBEEF -> instrD stays at the captured word; pcF is unchanged.
REQ-039 stallD=1 and flushD=1 in the same cycle -> instrD=0, pcD=0, buffer EMPTY.
REQ-040 With FETCH_ADEL_CHECK_EN, jr_targetD=0xBFC00102 -> next cycle adelD=1, instrD=0; without the macro, adelD=0.
REQ-041 jrD=1 and branch_takenD=1 together -> pcF=jr_targetD; rst pulse during a HELD stall -> pcF=RESET_PC, instrD=0.
